// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with ready-handshaked memory states
// and parameter-selectable andi/ori/slti and bne support.
module mc_controller #(
  parameter bit SUPPORT_IMM_LOGIC = 1'b1,
  parameter bit SUPPORT_BNE       = 1'b1,
  parameter bit MEM_HANDSHAKE     = 1'b1
) (
  input  logic       i_clk_w,
  input  logic       i_rst_w,
  input  logic [5:0] i_op_w,
  input  logic [5:0] i_funct_w,
  input  logic       i_zero_w,
  input  logic       i_mem_ready_w,
  output logic       o_iord_w,
  output logic       o_mem_read_w,
  output logic       o_mem_write_w,
  output logic       o_ir_write_w,
  output logic       o_reg_dst_w,
  output logic       o_mem_to_reg_w,
  output logic       o_reg_write_w,
  output logic       o_alu_src_a_w,
  output logic [1:0] o_alu_src_b_w,
  output logic       o_imm_zext_w,
  output logic [2:0] o_alu_control_w,
  output logic [1:0] o_pc_src_w,
  output logic       o_pc_en_w,
  output logic       o_illegal_w,
  output logic [3:0] o_state_w
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTEX = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, IMMEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_J = 6'b000010;
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d, funct_q, funct_d;
  logic       ready, funct_ok, op_ok;
  logic [2:0] r_alu, i_alu;
  logic       ir_write, pc_en, mem_write, reg_write, illegal;
  assign ready = MEM_HANDSHAKE ? i_mem_ready_w : 1'b1;
  assign funct_ok = i_funct_w inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign op_ok = (i_op_w == OP_R) ? funct_ok :
                 (i_op_w inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) ||
                 (SUPPORT_BNE && i_op_w == OP_BNE) ||
                 (SUPPORT_IMM_LOGIC && (i_op_w inside {OP_ANDI, OP_ORI, OP_SLTI}));
  assign r_alu = (funct_q == 6'b100010) ? 3'b110 :
                 (funct_q == 6'b100100) ? 3'b000 :
                 (funct_q == 6'b100101) ? 3'b001 :
                 (funct_q == 6'b101010) ? 3'b111 : 3'b010;
  assign i_alu = (op_q == OP_ANDI) ? 3'b000 :
                 (op_q == OP_ORI)  ? 3'b001 :
                 (op_q == OP_SLTI) ? 3'b111 : 3'b010;
  assign op_d    = (state_q == DECODE) ? i_op_w : op_q;
  assign funct_d = (state_q == DECODE) ? i_funct_w : funct_q;
  always_comb begin
    state_d         = FETCH;
    o_iord_w        = 1'b0;
    o_mem_read_w    = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    o_reg_dst_w     = 1'b0;
    o_mem_to_reg_w  = 1'b0;
    reg_write       = 1'b0;
    o_alu_src_a_w   = 1'b0;
    o_alu_src_b_w   = 2'b00;
    o_imm_zext_w    = 1'b0;
    o_alu_control_w = 3'b000;
    o_pc_src_w      = 2'b00;
    pc_en           = 1'b0;
    illegal         = 1'b0;
    case (state_q)
      FETCH: begin
        o_mem_read_w    = 1'b1;
        o_alu_src_b_w   = 2'b01;
        o_alu_control_w = 3'b010;
        ir_write        = ready;
        pc_en           = ready;
        state_d         = ready ? DECODE : FETCH;
      end
      DECODE: begin
        o_alu_src_b_w   = 2'b11;
        o_alu_control_w = 3'b010;
        illegal         = !op_ok;
        state_d = !op_ok                              ? FETCH  :
                  (i_op_w inside {OP_LW, OP_SW})      ? MEMADR :
                  (i_op_w == OP_R)                    ? RTEX   :
                  (i_op_w inside {OP_BEQ, OP_BNE})    ? BRANCH :
                  (i_op_w == OP_J)                    ? JUMP   : IMMEX;
      end
      MEMADR: begin
        o_alu_src_a_w   = 1'b1;
        o_alu_src_b_w   = 2'b10;
        o_alu_control_w = 3'b010;
        state_d         = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        o_iord_w     = 1'b1;
        o_mem_read_w = 1'b1;
        state_d      = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        o_mem_to_reg_w = 1'b1;
        reg_write      = 1'b1;
      end
      MEMWR: begin
        o_iord_w  = 1'b1;
        mem_write = 1'b1;
        state_d   = ready ? FETCH : MEMWR;
      end
      RTEX: begin
        o_alu_src_a_w   = 1'b1;
        o_alu_control_w = r_alu;
        state_d         = ALUWB;
      end
      ALUWB: begin
        o_reg_dst_w = 1'b1;
        reg_write   = 1'b1;
      end
      BRANCH: begin
        o_alu_src_a_w   = 1'b1;
        o_alu_control_w = 3'b110;
        o_pc_src_w      = 2'b01;
        pc_en           = (op_q == OP_BNE) ? !i_zero_w : i_zero_w;
      end
      IMMEX: begin
        o_alu_src_a_w   = 1'b1;
        o_alu_src_b_w   = 2'b10;
        o_alu_control_w = i_alu;
        o_imm_zext_w    = op_q inside {OP_ANDI, OP_ORI};
        state_d         = IMMWB;
      end
      IMMWB: reg_write = 1'b1;
      JUMP: begin
        o_pc_src_w = 2'b10;
        pc_en      = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
  // Reset gates the write-type enables combinationally so they drop in the very cycle it asserts.
  assign o_ir_write_w  = ir_write & i_rst_w;
  assign o_pc_en_w     = pc_en & i_rst_w;
  assign o_mem_write_w = mem_write & i_rst_w;
  assign o_reg_write_w = reg_write & i_rst_w;
  assign o_illegal_w   = illegal & i_rst_w;
  assign o_state_w     = state_q;
  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state_q <= FETCH;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed per-cycle checks of the multicycle control FSM,
// plus an instance with immediate-logic ops disabled.
module tb_mc_controller;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, ready = 1'b0;
  logic       iord, mrd, mwr, irw, dst, m2r, rw, srca, zext, pcen, ill;
  logic [1:0] srcb, pcsrc;
  logic [2:0] alu;
  logic [3:0] st;
  logic       n_iord, n_mrd, n_mwr, n_irw, n_dst, n_m2r, n_rw, n_srca, n_zext, n_pcen, n_ill;
  logic [1:0] n_srcb, n_pcsrc;
  logic [2:0] n_alu;
  logic [3:0] n_st;
  int pass = 0, total = 0;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
    BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;
  always #5 clk = ~clk;
  mc_controller dut (
    .i_clk_w(clk), .i_rst_w(rst_n), .i_op_w(op), .i_funct_w(funct), .i_zero_w(zero),
    .i_mem_ready_w(ready), .o_iord_w(iord), .o_mem_read_w(mrd), .o_mem_write_w(mwr),
    .o_ir_write_w(irw), .o_reg_dst_w(dst), .o_mem_to_reg_w(m2r), .o_reg_write_w(rw),
    .o_alu_src_a_w(srca), .o_alu_src_b_w(srcb), .o_imm_zext_w(zext), .o_alu_control_w(alu),
    .o_pc_src_w(pcsrc), .o_pc_en_w(pcen), .o_illegal_w(ill), .o_state_w(st));
  mc_controller #(.SUPPORT_IMM_LOGIC(1'b0)) dut_nl (
    .i_clk_w(clk), .i_rst_w(rst_n), .i_op_w(op), .i_funct_w(funct), .i_zero_w(zero),
    .i_mem_ready_w(ready), .o_iord_w(n_iord), .o_mem_read_w(n_mrd), .o_mem_write_w(n_mwr),
    .o_ir_write_w(n_irw), .o_reg_dst_w(n_dst), .o_mem_to_reg_w(n_m2r), .o_reg_write_w(n_rw),
    .o_alu_src_a_w(n_srca), .o_alu_src_b_w(n_srcb), .o_imm_zext_w(n_zext),
    .o_alu_control_w(n_alu), .o_pc_src_w(n_pcsrc), .o_pc_en_w(n_pcen), .o_illegal_w(n_ill),
    .o_state_w(n_st));
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass++;
  endtask
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    @(negedge clk);
    op = o; funct = f; zero = z; ready = r;
    #1;
  endtask
  initial begin
    ready = 1'b1;
    #1;
    check("rst_state", st, 0); check("rst_irw", irw, 0); check("rst_pcen", pcen, 0);
    check("rst_ill", ill, 0);
    @(negedge clk); ready = 1'b0; rst_n = 1'b1;
    step(ANDI, 0, 0, 1); check("andi_f", st, 0); check("nl_f", n_st, 0);
    step(ANDI, 0, 0, 1); check("andi_d", st, 1); check("andi_ill", ill, 0);
    check("nl_ill", n_ill, 1); check("nl_ill_rw", n_rw, 0);
    step(BAD, 0, 0, 1); check("andi_ex", st, 9); check("andi_alu", alu, 3'b000);
    check("andi_zext", zext, 1); check("nl_back", n_st, 0);
    step(BAD, 0, 0, 1); check("andi_wb", st, 10); check("andi_rw", rw, 1);
    step(LW, 0, 0, 1); check("lw_f", st, 0); check("lw_irw", irw, 1); check("lw_pcen", pcen, 1);
    check("lw_mrd", mrd, 1); check("lw_fb", srcb, 1); check("lw_falu", alu, 3'b010);
    check("lw_frw", rw, 0);
    step(LW, 0, 0, 1); check("lw_d", st, 1); check("lw_db", srcb, 3);
    step(BAD, 0, 0, 1); check("lw_ma", st, 2); check("lw_maa", srca, 1); check("lw_mab", srcb, 2);
    step(BAD, 0, 0, 1); check("lw_mr", st, 3); check("lw_iord", iord, 1); check("lw_mrrd", mrd, 1);
    check("lw_mrrw", rw, 0);
    step(BAD, 0, 0, 1); check("lw_wb", st, 4); check("lw_rw", rw, 1); check("lw_m2r", m2r, 1);
    check("lw_dst", dst, 0);
    step(ADDI, 0, 0, 0); check("wt_f1", st, 0); check("wt_irw1", irw, 0); check("wt_pc1", pcen, 0);
    step(ADDI, 0, 0, 0); check("wt_f2", st, 0); check("wt_irw2", irw, 0);
    step(ADDI, 0, 0, 1); check("wt_f3", st, 0); check("wt_irw3", irw, 1); check("wt_pc3", pcen, 1);
    step(ADDI, 0, 0, 1); check("addi_d", st, 1);
    step(BAD, 0, 0, 1); check("addi_ex", st, 9); check("addi_alu", alu, 3'b010);
    check("addi_zext", zext, 0);
    step(BAD, 0, 0, 1); check("addi_wb", st, 10); check("addi_rw", rw, 1);
    step(BEQ, 0, 0, 1); check("beq_f", st, 0);
    step(BEQ, 0, 0, 1); check("beq_d", st, 1);
    step(BAD, 0, 1, 1); check("beq_br", st, 8); check("beq_pcen", pcen, 1);
    check("beq_pcsrc", pcsrc, 1); check("beq_alu", alu, 3'b110);
    step(BNE, 0, 0, 1); check("bne_f", st, 0);
    step(BNE, 0, 0, 1); check("bne_d", st, 1);
    step(BAD, 0, 1, 1); check("bne_br", st, 8); check("bne_pcen", pcen, 0);
    step(BAD, 0, 0, 1); check("bad_f", st, 0);
    step(BAD, 0, 0, 1); check("bad_d", st, 1); check("bad_ill", ill, 1); check("bad_rw", rw, 0);
    check("bad_mw", mwr, 0);
    step(R, 0, 0, 1); check("rf0_f", st, 0); check("rf0_ill0", ill, 0);
    step(R, 0, 0, 1); check("rf0_d", st, 1); check("rf0_ill", ill, 1);
    step(R, 6'b100010, 0, 1); check("sub_f", st, 0);
    step(R, 6'b100010, 0, 1); check("sub_d", st, 1); check("sub_ill", ill, 0);
    step(BAD, 0, 0, 1); check("sub_ex", st, 6); check("sub_alu", alu, 3'b110);
    check("sub_a", srca, 1); check("sub_b", srcb, 0);
    step(BAD, 0, 0, 1); check("sub_wb", st, 7); check("sub_dst", dst, 1); check("sub_rw", rw, 1);
    step(ORI, 0, 0, 1); check("ori_f", st, 0);
    step(ORI, 0, 0, 1); check("ori_d", st, 1);
    step(BAD, 0, 0, 1); check("ori_ex", st, 9); check("ori_alu", alu, 3'b001);
    check("ori_zext", zext, 1);
    step(BAD, 0, 0, 1); check("ori_wb", st, 10); check("ori_rw", rw, 1);
    step(SW, 0, 0, 1); check("sw_f", st, 0);
    step(SW, 0, 0, 1); check("sw_d", st, 1);
    step(BAD, 0, 0, 1); check("sw_ma", st, 2);
    step(BAD, 0, 0, 0); check("sw_wr1", st, 5); check("sw_mw1", mwr, 1); check("sw_iord", iord, 1);
    step(BAD, 0, 0, 0); check("sw_wr2", st, 5); check("sw_mw2", mwr, 1);
    #2; rst_n = 1'b0; ready = 1'b1;
    #1; check("rstm_mw", mwr, 0); check("rstm_st", st, 0); check("rstm_irw", irw, 0);
    check("rstm_pcen", pcen, 0);
    @(negedge clk); ready = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1; check("rel_st", st, 0); check("rel_mw", mwr, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
